// File: rtl/config_arbiter.sv
// config_arbiter
// Three requesters share one configuration bus. A round-robin arbiter picks
// one pending request, checks that its address targets a known peripheral
// (top bits 01 = UART, 10 = VGA) and drives it onto the bus until the bus
// accepts it or a timeout expires. The requester then gets a one-cycle
// done pulse, with an error flag if the address was illegal or the bus
// never accepted.
//
// Ports
//   clk        single clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester write request (bit i = requester i)
//   req_addr   packed addresses, requester i at [i*WIDTH_CONFIG_ADDR +: WIDTH_CONFIG_ADDR]
//   req_data   packed data, same packing
//   req_done   one-cycle completion pulse per requester
//   req_err    error flag, meaningful only together with req_done
//   c_addr     configuration bus address (0 while c_valid is low)
//   c_data     configuration bus data    (0 while c_valid is low)
//   c_valid    configuration bus valid
//   c_ready    configuration bus accepting
//   busy       high whenever the FSM is not idle
//   dbg_state  current FSM state (0 IDLE, 1 BUS, 2 DONE)
//
// Handshake: a bus transfer happens in the cycle where c_valid and c_ready
// are both high. c_valid, c_addr and c_data stay constant from the first
// BUS cycle until that cycle (or the timeout cycle); c_ready is never
// required to be stable. Requesters hold req_valid/addr/data until their
// req_done; the latched copy is used, so later input changes are ignored.
module config_arbiter #(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int TIMEOUT           = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     req_valid,
  input  logic [3*WIDTH_CONFIG_ADDR-1:0] req_addr,
  input  logic [3*WIDTH_CONFIG_DATA-1:0] req_data,
  output logic [2:0]                     req_done,
  output logic [2:0]                     req_err,
  output logic [WIDTH_CONFIG_ADDR-1:0]   c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0]   c_data,
  output logic                           c_valid,
  input  logic                           c_ready,
  output logic                           busy,
  output logic [1:0]                     dbg_state
);

  localparam int WA = WIDTH_CONFIG_ADDR;
  localparam int WD = WIDTH_CONFIG_DATA;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [WA-1:0]   c_addr_q, c_addr_d;
  logic [WD-1:0]   c_data_q, c_data_d;
  logic            c_valid_q, c_valid_d;
  logic [2:0]      req_done_q, req_done_d;
  logic [2:0]      req_err_q, req_err_d;
  logic            busy_q, busy_d;

  // Arbitration helpers
  logic [1:0]      p0, p1, p2;
  logic [1:0]      win;
  logic [WA-1:0]   sel_addr;
  logic [WD-1:0]   sel_data;
  logic            sel_legal;

  always_comb begin
    // Priority order starts just after the last served requester.
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last_grant_q)
      2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase

    if (req_valid[p0])      win = p0;
    else if (req_valid[p1]) win = p1;
    else                    win = p2;

    case (win)
      2'd1: begin
        sel_addr = req_addr[WA +: WA];
        sel_data = req_data[WD +: WD];
      end
      2'd2: begin
        sel_addr = req_addr[2*WA +: WA];
        sel_data = req_data[2*WD +: WD];
      end
      default: begin
        sel_addr = req_addr[0 +: WA];
        sel_data = req_data[0 +: WD];
      end
    endcase

    sel_legal = (sel_addr[WA-1:WA-2] == 2'b01) || (sel_addr[WA-1:WA-2] == 2'b10);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    c_addr_d     = c_addr_q;
    c_data_d     = c_data_q;
    c_valid_d    = c_valid_q;
    req_done_d   = 3'b000;
    req_err_d    = 3'b000;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = win;
          cnt_d   = 8'd0;
          if (sel_legal) begin
            state_d   = BUS;
            c_valid_d = 1'b1;
            c_addr_d  = sel_addr;
            c_data_d  = sel_data;
          end else begin
            // Unknown peripheral: report the error without touching the bus.
            state_d    = DONE;
            req_done_d = 3'b001 << win;
            req_err_d  = 3'b001 << win;
          end
        end
      end

      BUS: begin
        if (c_ready) begin
          // Acceptance wins even in the timeout cycle.
          state_d    = DONE;
          c_valid_d  = 1'b0;
          c_addr_d   = '0;
          c_data_d   = '0;
          req_done_d = 3'b001 << grant_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          c_valid_d  = 1'b0;
          c_addr_d   = '0;
          c_data_d   = '0;
          req_done_d = 3'b001 << grant_q;
          req_err_d  = 3'b001 << grant_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
        cnt_d        = 8'd0;
      end

      default: begin
        state_d   = IDLE;
        c_valid_d = 1'b0;
        c_addr_d  = '0;
        c_data_d  = '0;
        cnt_d     = 8'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      cnt_q        <= 8'd0;
      c_addr_q     <= '0;
      c_data_q     <= '0;
      c_valid_q    <= 1'b0;
      req_done_q   <= 3'b000;
      req_err_q    <= 3'b000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      c_addr_q     <= c_addr_d;
      c_data_q     <= c_data_d;
      c_valid_q    <= c_valid_d;
      req_done_q   <= req_done_d;
      req_err_q    <= req_err_d;
      busy_q       <= busy_d;
    end
  end

  assign c_addr    = c_addr_q;
  assign c_data    = c_data_q;
  assign c_valid   = c_valid_q;
  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_config_arbiter.sv
// Bench for config_arbiter: directed scenarios followed by random traffic.
// The reference model is transaction level: a set of pending requests, a
// round-robin pointer and the bus-ready delay chosen for each transaction
// determine who is served, how long c_valid stays high and whether the
// completion carries an error.
module tb_config_arbiter;

  localparam int WA = 4;
  localparam int WD = 8;
  localparam int T  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      req_valid = '0;
  logic [3*WA-1:0] req_addr = '0;
  logic [3*WD-1:0] req_data = '0;
  logic [2:0]      req_done;
  logic [2:0]      req_err;
  logic [WA-1:0]   c_addr;
  logic [WD-1:0]   c_data;
  logic            c_valid;
  logic            c_ready = 1'b0;
  logic            busy;
  logic [1:0]      dbg_state;

  config_arbiter #(
    .WIDTH_CONFIG_ADDR(WA),
    .WIDTH_CONFIG_DATA(WD),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_done(req_done),
    .req_err(req_err),
    .c_addr(c_addr),
    .c_data(c_data),
    .c_valid(c_valid),
    .c_ready(c_ready),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model state
  int            total = 0;
  int            bad   = 0;
  bit [2:0]      pend  = '0;
  bit [2:0]      drop  = '0;
  logic [WA-1:0] a_m [3];
  logic [WD-1:0] d_m [3];
  int            lg = 2;
  int            grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Driver: pending requesters present their held request; everybody else
  // shows random garbage that the arbiter must ignore.
  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = pend[i] & ~drop[i];
      req_addr[i*WA +: WA] = req_valid[i] ? a_m[i] : WA'($urandom);
      req_data[i*WD +: WD] = req_valid[i] ? d_m[i] : WD'($urandom);
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i, input logic [WA-1:0] a, input logic [WD-1:0] d);
    pend[i] = 1'b1;
    a_m[i]  = a;
    d_m[i]  = d;
  endtask

  function automatic int pick();
    for (int k = 1; k <= 3; k++) begin
      if (pend[(lg + k) % 3]) return (lg + k) % 3;
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".req_done"}, 32'(req_done), 32'd0);
    chk({tag, ".req_err"},  32'(req_err),  32'd0);
    chk({tag, ".c_valid"},  32'(c_valid),  32'd0);
    chk({tag, ".c_addr"},   32'(c_addr),   32'd0);
    chk({tag, ".c_data"},   32'(c_data),   32'd0);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    pend    = '0;
    drop    = '0;
    c_ready = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset.state", 32'(dbg_state), 32'd0);
    lg  = 2;
    rst = 1'b1;
  endtask

  // One transaction, starting in an IDLE cycle at posedge+1. d is the BUS
  // cycle index in which c_ready is raised (d >= T means never).
  task automatic run_txn(input int d);
    int   w;
    int   k;
    int   nv;
    int   exp_nv;
    bit   legal;
    bit   err;
    logic [2:0] oh;
    w = pick();
    if (w < 0) begin
      tick();
      check_quiet("no_req");
      return;
    end
    oh    = 3'b001 << w;
    legal = (a_m[w][WA-1:WA-2] == 2'b01) || (a_m[w][WA-1:WA-2] == 2'b10);
    c_ready = (d == 0);
    tick();
    grant_log.push_back(w);
    if (!legal) begin
      err = 1'b1;
      chk("illegal.c_valid", 32'(c_valid), 32'd0);
      chk("illegal.c_addr",  32'(c_addr),  32'd0);
    end else begin
      nv = 0;
      chk("grant.c_valid",  32'(c_valid),  32'd1);
      chk("grant.c_addr",   32'(c_addr),   32'(a_m[w]));
      chk("grant.c_data",   32'(c_data),   32'(d_m[w]));
      chk("grant.busy",     32'(busy),     32'd1);
      chk("grant.req_done", 32'(req_done), 32'd0);
      if (c_valid) nv++;
      // A held request may be withdrawn mid-transfer without aborting it.
      if ($urandom_range(0, 3) == 0) drop[w] = 1'b1;
      k = 0;
      forever begin
        tick();
        if (k == d || k == T - 1) break;
        chk("bus.c_valid", 32'(c_valid), 32'd1);
        chk("bus.c_addr",  32'(c_addr),  32'(a_m[w]));
        chk("bus.c_data",  32'(c_data),  32'(d_m[w]));
        if (c_valid) nv++;
        k++;
        c_ready = (k == d);
      end
      err    = (d >= T);
      exp_nv = (d < T) ? d + 1 : T;
      chk("valid_cycles", 32'(nv), 32'(exp_nv));
    end
    chk("done.req_done", 32'(req_done), 32'(oh));
    chk("done.req_err",  32'(req_err),  err ? 32'(oh) : 32'd0);
    chk("done.c_valid",  32'(c_valid),  32'd0);
    chk("done.c_addr",   32'(c_addr),   32'd0);
    chk("done.c_data",   32'(c_data),   32'd0);
    chk("done.busy",     32'(busy),     32'd1);
    pend[w] = 1'b0;
    drop[w] = 1'b0;
    lg      = w;
    c_ready = 1'($urandom);
    tick();
    check_quiet("after_done");
    c_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_m[i] = '0;
      d_m[i] = '0;
    end

    do_reset();

    // Single request with an immediately ready bus.
    new_req(0, 4'b0100, 8'h5A);
    run_txn(0);
    chk("single.grant", 32'(grant_log[$]), 32'd0);

    // All three requesting continuously from reset: 0,1,2,0.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 3; i++) new_req(i, 4'b0100 + 4'(i), 8'h10 + 8'(i));
    for (int n = 0; n < 4; n++) begin
      run_txn(0);
      new_req(grant_log[$], 4'b1000 + 4'(n), 8'h20 + 8'(n));
    end
    chk("rr.g0", 32'(grant_log[0]), 32'd0);
    chk("rr.g1", 32'(grant_log[1]), 32'd1);
    chk("rr.g2", 32'(grant_log[2]), 32'd2);
    chk("rr.g3", 32'(grant_log[3]), 32'd0);

    // Timeout with the bus never ready, then ready in the last BUS cycle.
    do_reset();
    new_req(0, 4'b1001, 8'hC3);
    run_txn(T + 2);
    new_req(1, 4'b0110, 8'h3C);
    run_txn(T - 1);

    // Illegal address from requester 1.
    do_reset();
    new_req(1, 4'b1100, 8'hAA);
    run_txn(0);
    chk("illegal.grant", 32'(grant_log[$]), 32'd1);

    // Reset in the middle of a BUS phase.
    do_reset();
    new_req(2, 4'b1000, 8'h77);
    c_ready = 1'b0;
    tick();
    chk("midrst.c_valid", 32'(c_valid), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_quiet("midrst.async");
    tick();
    check_quiet("midrst.held");
    lg  = 2;
    rst = 1'b1;
    run_txn(1);
    chk("midrst.regrant", 32'(grant_log[$]), 32'd2);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      int d;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          new_req(i, WA'($urandom), WD'($urandom));
      end
      if ($urandom_range(0, 3) == 0) d = $urandom_range(T - 2, T + 2);
      else                           d = $urandom_range(0, 4);
      run_txn(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_arbiter.md
CONFIG_ARBITER -- requirements
Module: config_arbiter

Interface
REQ-001 The block SHALL be clocked by one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter WIDTH_CONFIG_ADDR, default 4, configuration address width.
REQ-003 The block SHALL have parameter WIDTH_CONFIG_DATA, default 8, configuration data width.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, the maximum number of cycles c_valid is held awaiting c_ready (range 2..255).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid, input, 3 bits, one write request per requester (bit i = requester i).
REQ-008 The block SHALL have port req_addr, input, 3*WIDTH_CONFIG_ADDR bits, packed addresses, requester i at slice [i*W +: W].
REQ-009 The block SHALL have port req_data, input, 3*WIDTH_CONFIG_DATA bits, packed data, same packing.
REQ-010 The block SHALL have port req_done, output, 3 bits, one-cycle completion pulse per requester.
REQ-011 The block SHALL have port req_err, output, 3 bits, one-cycle error flag, valid only with req_done.
REQ-012 The block SHALL have port c_addr, output, WIDTH_CONFIG_ADDR bits, configuration bus address (01xx UART, 10xx VGA).
REQ-013 The block SHALL have port c_data, output, WIDTH_CONFIG_DATA bits, configuration bus data.
REQ-014 The block SHALL have port c_valid, output, 1 bit, configuration bus data valid.
REQ-015 The block SHALL have port c_ready, input, 1 bit, configuration bus free/accepting.
REQ-016 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, BUS and DONE, and all outputs SHALL be registered.
REQ-018 In IDLE, when any req_valid bit is high, the block SHALL select the winner round-robin starting at (last_grant+1) mod 3, latch its address/data and grant index, and leave IDLE in that cycle.
REQ-019 If the latched address's top two bits are 01 or 10, the FSM SHALL go to BUS; otherwise it SHALL go directly to DONE with error set, and the bus SHALL never be driven.
REQ-020 In BUS, c_valid SHALL be 1 with c_addr/c_data holding the latched values, stable until exit.
REQ-021 In BUS, when c_ready is 1, the transfer SHALL complete in that cycle and the FSM SHALL go to DONE with error clear.
REQ-022 In BUS, a cycle counter SHALL start at 0 on entry; if c_ready is still 0 when the counter equals TIMEOUT-1, the FSM SHALL go to DONE with error set.
REQ-023 If c_ready=1 in the timeout cycle, the transfer SHALL complete without error (success has priority).
REQ-024 DONE SHALL last exactly one cycle, during which req_done[grant]=1 and req_err[grant]=error, with all other bits 0; c_valid SHALL be 0; last_grant SHALL update to grant; the FSM SHALL return to IDLE.
REQ-025 Latency: req_valid high in IDLE at cycle N gives c_valid=1 at N+1; c_ready high at cycle M in BUS gives req_done at M+1; the next arbitration occurs no earlier than the IDLE cycle after DONE.
REQ-026 Requesters SHALL hold req_valid/addr/data until req_done; deasserting req_valid mid-transaction SHALL NOT abort it, and changes to unselected inputs SHALL be ignored.
REQ-027 Simultaneous requests SHALL be served one at a time, and no requester SHALL wait more than two other transactions.
REQ-028 c_addr/c_data SHALL be 0 whenever c_valid=0.

Reset
REQ-029 While rst=0, the FSM SHALL be in IDLE; c_valid, c_addr, c_data, req_done, req_err and busy SHALL be 0; the counter SHALL be 0; and last_grant SHALL be 2, so that requester 0 has first priority.
REQ-030 Reset asserted in BUS or DONE SHALL abort immediately with no req_done pulse, and requests still pending after reset release SHALL be re-arbitrated normally.

Verification
REQ-031 Single request, instant ready: req_valid=001, addr=0100, data=0x5A, c_ready=1 -> c_valid=1 with 0100/0x5A at N+1, req_done=001 and req_err=000 at N+2.
REQ-032 All three requesting continuously: req_valid=111, c_ready=1 -> grants in order 0,1,2,0, each transaction 3 cycles, with no requester skipped.
REQ-033 Timeout: TIMEOUT=16, c_ready=0 -> c_valid high for exactly 16 cycles, then req_done and req_err set for the granted requester, and c_valid=0.
REQ-034 Illegal address: requester 1 with addr=1100 -> c_valid never asserts, req_done=010 and req_err=010 one cycle after grant.
REQ-035 Ready on last cycle: c_ready rises in the 16th BUS cycle -> req_done with req_err=0.
REQ-036 Reset mid-BUS: rst=0 during c_valid -> outputs 0 asynchronously, no req_done; after release with req_valid=100 still held, requester 2 is granted.
